// File: rtl/pq_access_arbiter_pkg.sv
// pq_pkg: shared op encoding and arbiter FSM states for pq_access_arbiter
package pq_pkg;
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TOP  = 2'b11
    } pq_op_e;
    typedef enum logic {
        IDLE        = 1'b0,
        POP_CAPTURE = 1'b1
    } arb_state_e;
endpackage

// File: rtl/pq_access_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the granted client when en
// Ports: clk, reset (async, active-high), req[N], en (grant takes effect), gnt[N] (one-hot).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        nxt = ptr;
        // scanned farthest-first so the client nearest the pointer wins last
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
                nxt = PW'((idx + 1) % N);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else if (en && |gnt) ptr <= nxt;
    end
endmodule

// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter: arbitrates client PUSH/POP (and optional TOP peek) onto one max_priority_queue op port
// Ports: push_valid/push_data/push_ready and pop_req/pop_ack per client; pop_resp_* routes popped keys back;
// pq_* is the registered queue drive and queue status; count/full/empty track occupancy.
// Optional peek ports (peek_req/peek_ack) exist only when PQ_ARB_TOP_PEEK_EN is defined.
module pq_access_arbiter
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PQ_DEPTH    = 8,
    parameter int NUM_CLIENTS = 4,
    parameter int POP_GAP     = PQ_DEPTH / 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            push_valid,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] push_data,
    output logic [NUM_CLIENTS-1:0]            push_ready,
    input  logic [NUM_CLIENTS-1:0]            pop_req,
    output logic [NUM_CLIENTS-1:0]            pop_ack,
`ifdef PQ_ARB_TOP_PEEK_EN
    input  logic [NUM_CLIENTS-1:0]            peek_req,
    output logic [NUM_CLIENTS-1:0]            peek_ack,
`endif
    output logic                              pop_resp_valid,
    output logic [NUM_CLIENTS-1:0]            pop_resp_id,
    output logic [DATA_WIDTH-1:0]             pop_resp_data,
    output logic                              pop_resp_empty,
    output logic [DATA_WIDTH-1:0]             pq_data_in,
    output logic                              pq_valid_in,
    output logic [1:0]                        pq_op,
    output logic                              pq_ready_in,
    input  logic                              pq_ready_out,
    input  logic [DATA_WIDTH-1:0]             pq_out,
    input  logic                              pq_valid_out,
    output logic [$clog2(PQ_DEPTH+1)-1:0]     count,
    output logic                              full,
    output logic                              empty
);
    localparam int CW = $clog2(PQ_DEPTH + 1);
    localparam int GW = POP_GAP > 0 ? $clog2(POP_GAP + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PQ_DEPTH);
    // the ack cycle itself is the first cycle of the gap, so POP_GAP pops apart means POP_GAP-1 more
    localparam logic [GW-1:0] GAP_LOAD = GW'(POP_GAP > 1 ? POP_GAP - 1 : 0);
    arb_state_e state, state_nx;
    logic [GW-1:0] gap;
    logic [NUM_CLIENTS-1:0] push_gnt, peek_win, pend_id, grant_id;
    logic [DATA_WIDTH-1:0] push_sel;
    logic idle, q_empty, pop_any, any_rd, push_any, pop_issue, peek_issue, empty_grant, capture;
    assign idle = state == IDLE;
    assign q_empty = count == '0;
    assign full = count == DEPTH_C;
    assign empty = q_empty;
    assign capture = state == POP_CAPTURE;
    // an empty-queue pop is answered locally, so it ignores the gap and queue status
    rr_arbiter #(.N(NUM_CLIENTS)) u_pop_arb (
        .clk, .reset,
        .req(pop_req & {NUM_CLIENTS{idle && (q_empty || (pq_valid_out && gap == '0))}}),
        .en(1'b1),
        .gnt(pop_ack)
    );
    assign pop_any = |pop_ack;
`ifdef PQ_ARB_TOP_PEEK_EN
    logic [NUM_CLIENTS-1:0] peek_gnt;
    rr_arbiter #(.N(NUM_CLIENTS)) u_peek_arb (
        .clk, .reset,
        .req(peek_req & {NUM_CLIENTS{idle && (q_empty || pq_valid_out)}}),
        .en(!pop_any),
        .gnt(peek_gnt)
    );
    assign peek_ack = pop_any ? '0 : peek_gnt;
    assign peek_win = peek_ack;
`else
    assign peek_win = '0;
`endif
    assign grant_id = pop_ack | peek_win;
    assign any_rd = |grant_id;
    rr_arbiter #(.N(NUM_CLIENTS)) u_push_arb (
        .clk, .reset,
        .req(push_valid & {NUM_CLIENTS{pq_ready_out && count < DEPTH_C}}),
        .en(!any_rd),
        .gnt(push_gnt)
    );
    assign push_ready = any_rd ? '0 : push_gnt;
    assign push_any = |push_ready;
    assign pop_issue = pop_any && !q_empty;
    assign peek_issue = |peek_win && !q_empty;
    assign empty_grant = any_rd && q_empty;
    always_comb begin
        push_sel = '0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (push_ready[i]) push_sel = push_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    always_comb begin
        state_nx = (idle && any_rd && !q_empty) ? POP_CAPTURE : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            gap            <= '0;
            pend_id        <= '0;
            pq_valid_in    <= 1'b0;
            pq_ready_in    <= 1'b0;
            pq_op          <= OP_NOP;
            pq_data_in     <= '0;
            pop_resp_valid <= 1'b0;
            pop_resp_empty <= 1'b0;
            pop_resp_id    <= '0;
            pop_resp_data  <= '0;
        end else begin
            state          <= state_nx;
            count          <= push_any ? count + 1'b1 : pop_issue ? count - 1'b1 : count;
            gap            <= pop_issue ? GAP_LOAD : gap != '0 ? gap - 1'b1 : gap;
            pend_id        <= any_rd ? grant_id : pend_id;
            pq_valid_in    <= push_any | pop_issue | peek_issue;
            pq_ready_in    <= pop_issue;
            pq_op          <= push_any ? OP_PUSH : pop_issue ? OP_POP : peek_issue ? OP_TOP : OP_NOP;
            pq_data_in     <= push_any ? push_sel : '0;
            pop_resp_valid <= capture | empty_grant;
            pop_resp_empty <= empty_grant;
            pop_resp_id    <= capture ? pend_id : empty_grant ? grant_id : '0;
            pop_resp_data  <= capture ? pq_out : '0;
        end
    end
endmodule
